note_lane_array: RTL and testbench
==================================

# note_lane_array

Parametrised multi-lane falling-note engine for the rhythm-game display path. It holds up to `SLOTS` notes per lane and scrolls every active note down by `SPEED` rows per video frame. It judges button presses against a hit window and reports hits and misses. It also renders note blocks and the hit line into the 6-bit VGA colour stream. It sits between the song sequencer (spawn source) and the VGA pixel mux, replacing the single fixed green lane.

## Interface
- `NUM_LANES`, 4: number of lanes (1–8).
- `SLOTS`, 4: note slots per lane.
- `NOTE_H`, 35: note block height in rows.
- `SPEED`, 5: rows advanced per frame tick.
- `Y_HIT`, 450: hit-line row.
- `HIT_WIN`, 20: half-width of the hit window in rows.
- `Y_END`, 500: bottom-edge row at or beyond which a note is missed.
- `X0`, 160: left column of lane 0.
- `LANE_W`, 80: lane width in columns.

Ports:
- `clk`  in  1: pixel clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `col`  in  10: current VGA column.
- `row`  in  10: current VGA row.
- `valid`  in  1: visible-pixel flag.
- `frame_tick`  in  1: one-cycle pulse, once per frame, asserted during blanking.
- `spawn_valid`  in  1: spawn request.
- `spawn_lane`  in  3: target lane of the spawn request.
- `spawn_ready`  out  1: the spawn request is acceptable this cycle.
- `press`  in  NUM_LANES: synchronised, debounced button levels.
- `lane_rgb`  out  6: pixel colour, registered.
- `hit_pulse`  out  1: one-cycle pulse per hit.
- `miss_pulse`  out  1: one-cycle pulse per miss.
- `hit_count`  out  16: saturating hit counter.
- `miss_count`  out  16: saturating miss counter.

## Operation
- **Per-slot state:** `active` (1 bit) and `y` (10 bits, the note's bottom row). The note covers rows `y-NOTE_H+1 .. y`. Invariant: `y >= NOTE_H` whenever `active`, so `y-NOTE_H` never underflows.
- **Spawn:**
  - `spawn_ready` is combinational. It is high when `spawn_lane < NUM_LANES` and that lane has a free slot.
  - Accept on `spawn_valid & spawn_ready`. The lowest-index free slot is loaded with `active=1`, `y=NOTE_H`.
  - A request to an out-of-range lane is never accepted.
- **Scroll (on `frame_tick`), per active slot:**
  - If `y >= Y_END`, clear the slot and count one miss.
  - Otherwise `y <= y + SPEED`.
- **Judge:**
  - A press event is a rising edge of `press[i]`, detected with an internal register per lane.
  - On a press event in lane i, take the active slot with the largest `y` inside `[Y_HIT-HIT_WIN, Y_HIT+HIT_WIN]`. Clear it and count one hit.
  - A press with no note in the window has no effect.
- **Pulses and counters:**
  - `hit_pulse` is the OR of all hits in the cycle; `miss_pulse` is the OR of all misses in the cycle.
  - `hit_count` adds the number of hits in the cycle; `miss_count` adds the number of misses in the cycle.
  - Both counters saturate at 16'hFFFF.
- **Render:**
  - Lane index is `(col-X0)/LANE_W`, valid when `X0 <= col < X0+NUM_LANES*LANE_W`. The division is implemented by compare against the constant lane edges, not a divider.
  - Priority, highest first:
    1. `!valid` → 0.
    2. The pixel lies inside any active note of the lane → lane colour.
    3. `row == Y_HIT` inside the lane span → 6'b111111.
    4. Otherwise → 0.
  - Lane colour by index mod 4: 001100, 110000, 111100, 000011.

## Timing
- **Reset:**
  - All slots inactive and all edge registers 0.
  - `lane_rgb=0`, `hit_pulse=0`, `miss_pulse=0`, `hit_count=0`, `miss_count=0`.
  - `spawn_ready` is high whenever `spawn_lane` is in range.
- **Reset mid-operation:** asserting reset clears all notes immediately (asynchronous). Releasing it takes effect on the next `clk` edge.
- **Latencies:**
  - `lane_rgb` lags `col`/`row`/`valid` by exactly 1 cycle. The VGA mux delays sync signals by 1 cycle to match.
  - A spawned note is visible from the cycle after acceptance.
  - `hit_pulse` and `miss_pulse` assert the cycle after the triggering press edge or tick.
  - The counters update in the same edge as the pulses.
- **Simultaneous events in one cycle:**
  - Hit and tick on the same slot: the hit is judged on the pre-tick `y`. A hit slot is cleared and neither advanced nor missed.
  - Spawn and tick: the new note takes `y=NOTE_H` and is not advanced that frame.
  - A spawn into a slot freed by a hit or miss in the same cycle is not allowed. `spawn_ready` reflects pre-cycle occupancy only.
  - A hit in one lane and a miss in another: both pulses assert, and both counters increment.
- **Lane full:** `spawn_ready=0`. A held `spawn_valid` waits, and the request is accepted once a slot frees.

## Test plan
All scenarios use default parameters.
- **Reset:** assert `reset_n=0` mid-scroll → all outputs 0 on the following cycle and no notes drawn. Release, then spawn lane 0 → `spawn_ready=1` and the note is drawn at `row` 1..35, `col` 160..239, with `lane_rgb=001100` one cycle after the pixel.
- **Scroll and miss:** spawn lane 2, then give 93 ticks → `y=500` and the note is still drawn. On tick 94 → `miss_pulse` for 1 cycle and `miss_count=1`.
- **Hit window:** spawn lane 1, 79 ticks (`y=430`), then a press edge → `hit_pulse` and `hit_count=1`. Repeat with 78 ticks (`y=425`) → no hit, and the note keeps scrolling.
- **Lane full:** 4 spawns to lane 3 → `spawn_ready=0` on the 5th request. Once the oldest note is missed, the held request is accepted next cycle.
- **Simultaneous events:**
  - Press edge in lane 0 (`y=470`) in the same cycle as a tick → hit, no miss.
  - Spawn in the same cycle as a tick → new note `y=35`.
  - Miss in lane 1 in the same cycle as a hit in lane 0 → both pulses, both counters +1.
- **Range and render:** `spawn_lane=5` → never accepted. Pixel at `row=450`, `col=400`, `valid=1` with no note present → `lane_rgb=111111`. Same pixel with `valid=0` → 0.

Source files
------------

// File: rtl/note_lane_array.sv
// note_lane_array: multi-lane falling-note engine.
// Each lane holds up to SLOTS notes that scroll down by SPEED rows per
// frame tick. Button rising edges are judged against the hit window around
// the hit line. Notes and the hit line are rendered into a registered 6-bit
// colour stream that trails the pixel coordinates by one clock.
module note_lane_array #(
  parameter int NUM_LANES = 4,
  parameter int SLOTS     = 4,
  parameter int NOTE_H    = 35,
  parameter int SPEED     = 5,
  parameter int Y_HIT     = 450,
  parameter int HIT_WIN   = 20,
  parameter int Y_END     = 500,
  parameter int X0        = 160,
  parameter int LANE_W    = 80
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [9:0]           col,
  input  logic [9:0]           row,
  input  logic                 valid,
  input  logic                 frame_tick,
  input  logic                 spawn_valid,
  input  logic [2:0]           spawn_lane,
  output logic                 spawn_ready,
  input  logic [NUM_LANES-1:0] press,
  output logic [5:0]           lane_rgb,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam logic [9:0] NOTE_H_V = 10'(NOTE_H);
  localparam logic [9:0] SPEED_V  = 10'(SPEED);
  localparam logic [9:0] WIN_LO   = 10'(Y_HIT - HIT_WIN);
  localparam logic [9:0] WIN_HI   = 10'(Y_HIT + HIT_WIN);
  localparam logic [9:0] Y_END_V  = 10'(Y_END);
  localparam logic [9:0] Y_HIT_V  = 10'(Y_HIT);
  localparam int         CW       = $clog2(NUM_LANES * SLOTS + 1);

  logic                 active    [NUM_LANES][SLOTS];
  logic [9:0]           y         [NUM_LANES][SLOTS];
  logic                 active_nx [NUM_LANES][SLOTS];
  logic [9:0]           y_nx      [NUM_LANES][SLOTS];
  logic [SLOTS-1:0]     hit_mask  [NUM_LANES];
  logic [NUM_LANES-1:0] lane_hit;
  logic [NUM_LANES-1:0] press_q;
  logic [NUM_LANES-1:0] press_edge;
  logic [CW-1:0]        hit_n;
  logic [CW-1:0]        miss_n;
  logic                 spawn_fire;
  logic                 spawn_done;
  logic [5:0]           rgb_nx;

  function automatic logic [5:0] lane_colour(input int l);
    case (l % 4)
      0:       return 6'b001100;
      1:       return 6'b110000;
      2:       return 6'b111100;
      default: return 6'b000011;
    endcase
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign press_edge = press & ~press_q;
  assign spawn_fire = spawn_valid & spawn_ready;

  // Ready when the requested lane exists and has at least one free slot right now.
  always_comb begin
    spawn_ready = 1'b0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int s = 0; s < SLOTS; s++)
        if (int'(spawn_lane) == l && !active[l][s]) spawn_ready = 1'b1;
  end

  // Per lane, pick the lowest in-window note (largest y) for a press edge; first slot wins ties.
  always_comb begin
    logic       found;
    logic [9:0] best;
    for (int l = 0; l < NUM_LANES; l++) begin
      found       = 1'b0;
      best        = '0;
      hit_mask[l] = '0;
      for (int s = 0; s < SLOTS; s++) begin
        if (press_edge[l] && active[l][s] && y[l][s] >= WIN_LO && y[l][s] <= WIN_HI &&
            (!found || y[l][s] > best)) begin
          found          = 1'b1;
          best           = y[l][s];
          hit_mask[l]    = '0;
          hit_mask[l][s] = 1'b1;
        end
      end
      lane_hit[l] = found;
    end
  end

  // Next slot state: hits clear first, then scroll/miss on tick, then load a spawn into a previously free slot.
  always_comb begin
    active_nx  = active;
    y_nx       = y;
    miss_n     = '0;
    hit_n      = '0;
    spawn_done = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_hit[l]) hit_n = hit_n + CW'(1);
      for (int s = 0; s < SLOTS; s++) begin
        if (hit_mask[l][s]) begin
          active_nx[l][s] = 1'b0;
        end else if (active[l][s] && frame_tick) begin
          if (y[l][s] >= Y_END_V) begin
            active_nx[l][s] = 1'b0;
            miss_n          = miss_n + CW'(1);
          end else begin
            y_nx[l][s] = y[l][s] + SPEED_V;
          end
        end
      end
    end
    for (int l = 0; l < NUM_LANES; l++)
      for (int s = 0; s < SLOTS; s++)
        if (spawn_fire && int'(spawn_lane) == l && !active[l][s] && !spawn_done) begin
          active_nx[l][s] = 1'b1;
          y_nx[l][s]      = NOTE_H_V;
          spawn_done      = 1'b1;
        end
  end

  // Pixel colour: lane found by comparing against constant lane edges; notes win over the hit line.
  always_comb begin
    logic note_px;
    rgb_nx  = '0;
    note_px = 1'b0;
    if (valid) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if ({1'b0, col} >= 11'(X0 + l * LANE_W) && {1'b0, col} < 11'(X0 + (l + 1) * LANE_W)) begin
          note_px = 1'b0;
          for (int s = 0; s < SLOTS; s++)
            if (active[l][s] && row <= y[l][s] && row > y[l][s] - NOTE_H_V) note_px = 1'b1;
          if (note_px)             rgb_nx = lane_colour(l);
          else if (row == Y_HIT_V) rgb_nx = 6'b111111;
        end
      end
    end
  end

  // Register slot state, press history, pulses, saturating counters and the output pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active     <= '{default: 1'b0};
      y          <= '{default: 10'd0};
      press_q    <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      lane_rgb   <= '0;
    end else begin
      active     <= active_nx;
      y          <= y_nx;
      press_q    <= press;
      hit_pulse  <= (hit_n != '0);
      miss_pulse <= (miss_n != '0);
      hit_count  <= sat_add(hit_count, hit_n);
      miss_count <= sat_add(miss_count, miss_n);
      lane_rgb   <= rgb_nx;
    end
  end

endmodule

// File: tb/tb_note_lane_array.sv
// tb_note_lane_array: scoreboard bench for note_lane_array.
// Expected pixel colours and pulse/counter values are queued when the
// stimulus is driven and compared once the DUT has registered them.
module tb_note_lane_array;

  localparam logic [5:0] C0   = 6'b001100;
  localparam logic [5:0] C1   = 6'b110000;
  localparam logic [5:0] C2   = 6'b111100;
  localparam logic [5:0] C3   = 6'b000011;
  localparam logic [5:0] LINE = 6'b111111;

  localparam int SIG_RGB  = 0;
  localparam int SIG_HITP = 1;
  localparam int SIG_MISP = 2;
  localparam int SIG_HITC = 3;
  localparam int SIG_MISC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        valid;
  logic        frame_tick;
  logic        spawn_valid;
  logic [2:0]  spawn_lane;
  logic        spawn_ready;
  logic [3:0]  press;
  logic [5:0]  lane_rgb;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
    int          due;
  } sb_item_t;

  sb_item_t sb[$];
  int cycle     = 0;
  int vec_count = 0;
  int err_count = 0;
  int exp_hits  = 0;
  int exp_miss  = 0;

  note_lane_array dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .col         (col),
    .row         (row),
    .valid       (valid),
    .frame_tick  (frame_tick),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .press       (press),
    .lane_rgb    (lane_rgb),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      SIG_RGB:  return {10'd0, lane_rgb};
      SIG_HITP: return {15'd0, hit_pulse};
      SIG_MISP: return {15'd0, miss_pulse};
      SIG_HITC: return hit_count;
      default:  return miss_count;
    endcase
  endfunction

  task automatic expect_next(input string tag, input int sig, input logic [15:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sig = sig;
    it.exp = exp;
    it.due = cycle + 1;
    sb.push_back(it);
  endtask

  task automatic expect_pulses(input string tag, input logic h, input logic m);
    expect_next({tag, " hit_pulse"},  SIG_HITP, {15'd0, h});
    expect_next({tag, " miss_pulse"}, SIG_MISP, {15'd0, m});
    expect_next({tag, " hit_count"},  SIG_HITC, 16'(exp_hits));
    expect_next({tag, " miss_count"}, SIG_MISC, 16'(exp_miss));
  endtask

  task automatic step();
    sb_item_t it;
    @(posedge clk);
    #1;
    cycle++;
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      it = sb.pop_front();
      checkOutput(it.tag, observe(it.sig), it.exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] c, input logic [9:0] r, input logic v,
                               input logic [5:0] exp);
    col   = c;
    row   = r;
    valid = v;
    expect_next($sformatf("rgb c%0d r%0d v%0d", c, r, v), SIG_RGB, {10'd0, exp});
    step();
    valid = 1'b0;
  endtask

  task automatic spawn_note(input logic [2:0] lane, input logic with_tick, input logic rdy);
    spawn_valid = 1'b1;
    spawn_lane  = lane;
    frame_tick  = with_tick;
    #1;
    checkOutput($sformatf("spawn_ready lane%0d", lane), 16'(spawn_ready), 16'(rdy));
    step();
    spawn_valid = 1'b0;
    frame_tick  = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    col         = '0;
    row         = '0;
    valid       = 1'b0;
    frame_tick  = 1'b0;
    spawn_valid = 1'b0;
    spawn_lane  = 3'd0;
    press       = '0;
    step();
    step();

    // reset state
    checkOutput("reset lane_rgb",    16'(lane_rgb),   16'd0);
    checkOutput("reset hit_pulse",   16'(hit_pulse),  16'd0);
    checkOutput("reset miss_pulse",  16'(miss_pulse), 16'd0);
    checkOutput("reset hit_count",   hit_count,       16'd0);
    checkOutput("reset miss_count",  miss_count,      16'd0);
    checkOutput("reset spawn_ready", 16'(spawn_ready), 16'd1);
    reset_n = 1'b1;
    step();

    // spawn lane 0 and render its block at rows 1..35, cols 160..239
    spawn_note(3'd0, 1'b0, 1'b1);
    applyStimulus(10'd160, 10'd1,  1'b1, C0);
    applyStimulus(10'd239, 10'd35, 1'b1, C0);
    applyStimulus(10'd240, 10'd35, 1'b1, 6'd0);
    applyStimulus(10'd200, 10'd36, 1'b1, 6'd0);
    applyStimulus(10'd200, 10'd0,  1'b1, 6'd0);
    applyStimulus(10'd159, 10'd10, 1'b1, 6'd0);

    // lane 0 at y=470 (window top) pressed on a tick: hit judged pre-tick, no miss
    run_ticks(87);
    press[0]   = 1'b1;
    frame_tick = 1'b1;
    exp_hits   = 1;
    expect_pulses("hit+tick", 1'b1, 1'b0);
    step();
    frame_tick = 1'b0;
    expect_next("hit_pulse one-shot", SIG_HITP, 16'd0);
    applyStimulus(10'd200, 10'd460, 1'b1, 6'd0);
    press[0] = 1'b0;

    // lane 1 at y=430 (window bottom) is hit
    spawn_note(3'd1, 1'b0, 1'b1);
    run_ticks(79);
    press[1] = 1'b1;
    exp_hits = 2;
    expect_pulses("hit y430", 1'b1, 1'b0);
    step();
    press[1] = 1'b0;
    expect_next("hit_pulse drop", SIG_HITP, 16'd0);
    step();

    // lane 1 at y=425 is outside the window; lane 0 spawned later to line up a dual event
    spawn_note(3'd1, 1'b0, 1'b1);
    run_ticks(10);
    spawn_note(3'd0, 1'b0, 1'b1);
    run_ticks(68);
    press[1] = 1'b1;
    expect_pulses("press y425", 1'b0, 1'b0);
    step();
    press[1] = 1'b0;
    run_ticks(15);
    applyStimulus(10'd280, 10'd480, 1'b1, C1);
    applyStimulus(10'd200, 10'd450, 1'b1, C0);
    press[0]   = 1'b1;
    frame_tick = 1'b1;
    exp_hits   = 3;
    exp_miss   = 1;
    expect_pulses("hit0+miss1", 1'b1, 1'b1);
    step();
    frame_tick = 1'b0;
    press[0]   = 1'b0;
    expect_next("dual hit_pulse drop",  SIG_HITP, 16'd0);
    expect_next("dual miss_pulse drop", SIG_MISP, 16'd0);
    step();

    // spawn on a tick stays at y=35; then scroll lane 2 to y=500 and miss on tick 94
    spawn_note(3'd2, 1'b1, 1'b1);
    applyStimulus(10'd360, 10'd35, 1'b1, C2);
    applyStimulus(10'd360, 10'd36, 1'b1, 6'd0);
    applyStimulus(10'd360, 10'd1,  1'b1, C2);
    run_ticks(93);
    applyStimulus(10'd360, 10'd500, 1'b1, C2);
    frame_tick = 1'b1;
    exp_miss   = 2;
    expect_pulses("miss lane2", 1'b0, 1'b1);
    step();
    frame_tick = 1'b0;
    expect_next("miss_pulse one-shot", SIG_MISP, 16'd0);
    applyStimulus(10'd360, 10'd500, 1'b1, 6'd0);

    // lane 3 full: held request waits until the oldest note misses
    spawn_note(3'd3, 1'b0, 1'b1);
    run_ticks(1);
    spawn_note(3'd3, 1'b0, 1'b1);
    spawn_note(3'd3, 1'b0, 1'b1);
    spawn_note(3'd3, 1'b0, 1'b1);
    spawn_valid = 1'b1;
    spawn_lane  = 3'd3;
    #1;
    checkOutput("full ready", 16'(spawn_ready), 16'd0);
    run_ticks(92);
    checkOutput("full ready held", 16'(spawn_ready), 16'd0);
    frame_tick = 1'b1;
    exp_miss   = 3;
    expect_pulses("miss lane3", 1'b0, 1'b1);
    step();
    frame_tick = 1'b0;
    #1;
    checkOutput("freed ready", 16'(spawn_ready), 16'd1);
    step();
    spawn_valid = 1'b0;
    #1;
    checkOutput("refilled ready", 16'(spawn_ready), 16'd0);
    applyStimulus(10'd440, 10'd35,  1'b1, C3);
    applyStimulus(10'd440, 10'd480, 1'b1, C3);

    // out-of-range lanes never accepted; hit line and blanking rendering
    spawn_valid = 1'b1;
    spawn_lane  = 3'd5;
    #1;
    checkOutput("range lane5", 16'(spawn_ready), 16'd0);
    spawn_lane = 3'd4;
    #1;
    checkOutput("range lane4", 16'(spawn_ready), 16'd0);
    step();
    spawn_valid = 1'b0;
    applyStimulus(10'd400, 10'd450, 1'b1, LINE);
    applyStimulus(10'd400, 10'd450, 1'b0, 6'd0);
    applyStimulus(10'd480, 10'd450, 1'b1, 6'd0);
    applyStimulus(10'd160, 10'd450, 1'b1, LINE);
    applyStimulus(10'd159, 10'd450, 1'b1, 6'd0);

    // reset mid-operation clears notes and counters immediately
    spawn_lane = 3'd3;
    col        = 10'd440;
    row        = 10'd480;
    valid      = 1'b1;
    reset_n    = 1'b0;
    #1;
    checkOutput("async ready",      16'(spawn_ready), 16'd1);
    checkOutput("async hit_count",  hit_count,        16'd0);
    checkOutput("async miss_count", miss_count,       16'd0);
    step();
    checkOutput("rst lane_rgb",   16'(lane_rgb),   16'd0);
    checkOutput("rst hit_pulse",  16'(hit_pulse),  16'd0);
    checkOutput("rst miss_pulse", 16'(miss_pulse), 16'd0);
    reset_n = 1'b1;
    valid   = 1'b0;
    step();
    applyStimulus(10'd440, 10'd480, 1'b1, 6'd0);
    applyStimulus(10'd440, 10'd35,  1'b1, 6'd0);
    spawn_note(3'd0, 1'b0, 1'b1);
    applyStimulus(10'd200, 10'd20, 1'b1, C0);

    checkOutput("scoreboard drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
